// File: rtl/fns_pkg.sv
// Shared definitions for the Fibonacci-numeral-system codec: weight table,
// parameter range check and controller state encoding.
package fns_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // w0=1, w1=2, w(i)=w(i-1)+w(i-2)
  function automatic logic [63:0] fns_weight(input int unsigned i);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd1;
    b = 64'd2;
    if (i == 0) return a;
    for (int unsigned k = 1; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic bit fns_range_ok(input int unsigned data_w, input int unsigned code_w);
    return fns_weight(code_w) >= (64'd1 << data_w);
  endfunction

endpackage

// File: rtl/fns_step.sv
// Single-weight FNS step: greedy subtract when encoding, saturating
// accumulate plus adjacent-ones detection when decoding.
module fns_step #(
  parameter int unsigned W = 9
) (
  input  logic         mode_i,
  input  logic [W-1:0] val_i,
  input  logic [W-1:0] weight_i,
  input  logic         bit_i,
  input  logic         bit_hi_i,
  output logic [W-1:0] val_o,
  output logic         bit_o,
  output logic         adj_err_o
);

  logic [W:0] sum;

  always_comb begin
    sum       = {1'b0, val_i} + {1'b0, weight_i};
    val_o     = val_i;
    bit_o     = bit_i;
    adj_err_o = 1'b0;
    if (!mode_i) begin
      bit_o = (val_i >= weight_i);
      if (bit_o) val_o = val_i - weight_i;
    end else begin
      adj_err_o = bit_i & bit_hi_i;
      if (bit_i) val_o = sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/fns_codec_seq.sv
// Multi-cycle FNS encoder/decoder with valid/ready handshake; one weight
// is processed per clock, MSB first, through a shared fns_step instance.
module fns_codec_seq
  import fns_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CODE_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mode,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data,
  output logic [CODE_W-1:0] out_code
);

  localparam int unsigned WBITS = $clog2(fns_weight(CODE_W-1) + 64'd1);
  localparam int unsigned RW    = (DATA_W > WBITS) ? DATA_W : WBITS;
  // one extra bit so the decode accumulator can sit above 2^DATA_W-1
  localparam int unsigned VW    = (RW > DATA_W + 1) ? RW : DATA_W + 1;
  localparam int unsigned IW    = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  if (!fns_range_ok(DATA_W, CODE_W)) begin : g_range_chk
    $error("fns_codec_seq: w(CODE_W) must be >= 2^DATA_W");
  end

  logic [VW-1:0] wtab [CODE_W];
  for (genvar g = 0; g < CODE_W; g++) begin : g_wtab
    assign wtab[g] = VW'(fns_weight(g));
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic              mode_q;
  logic [VW-1:0]     val_q;
  logic [CODE_W-1:0] code_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              out_mode_q, out_err_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CODE_W-1:0] out_code_q;

  logic              accept;
  logic [CODE_W-1:0] code_sh, code_upd;
  logic              bit_hi, last;
  logic [VW-1:0]     step_val;
  logic              step_bit, step_adj, dec_err;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign out_mode  = out_mode_q;
  assign out_err   = out_err_q;
  assign out_data  = out_data_q;
  assign out_code  = out_code_q;

  assign code_sh = code_q >> idx_q;
  assign bit_hi  = (idx_q != IW'(CODE_W - 1)) & code_sh[1];
  assign last    = (idx_q == '0);

  fns_step #(.W(VW)) u_step (
    .mode_i    (mode_q),
    .val_i     (val_q),
    .weight_i  (wtab[idx_q]),
    .bit_i     (code_sh[0]),
    .bit_hi_i  (bit_hi),
    .val_o     (step_val),
    .bit_o     (step_bit),
    .adj_err_o (step_adj)
  );

  always_comb begin
    code_upd = code_q;
    if (!mode_q) code_upd[idx_q] = step_bit;
    dec_err = err_q | step_adj | (|step_val[VW-1:DATA_W]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = in_err ? DONE : RUN;
      RUN:     if (last) state_d = DONE;
      DONE: begin
        if (accept)         state_d = in_err ? DONE : RUN;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mode_q     <= 1'b0;
      val_q      <= '0;
      code_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      out_mode_q <= 1'b0;
      out_err_q  <= 1'b0;
      out_data_q <= '0;
      out_code_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= in_mode;
        if (in_err) begin
          out_mode_q <= in_mode;
          out_err_q  <= 1'b1;
          if (!in_mode) begin
            out_data_q <= in_data;
            out_code_q <= CODE_W'(in_data);
          end else begin
            out_data_q <= in_code[DATA_W-1:0];
            out_code_q <= in_code;
          end
        end else begin
          idx_q  <= IW'(CODE_W - 1);
          val_q  <= in_mode ? '0 : VW'(in_data);
          code_q <= in_mode ? in_code : '0;
          data_q <= in_data;
          err_q  <= 1'b0;
        end
      end else if (state_q == RUN) begin
        val_q  <= step_val;
        code_q <= code_upd;
        err_q  <= err_q | step_adj;
        idx_q  <= idx_q - 1'b1;
        if (last) begin
          out_mode_q <= mode_q;
          if (!mode_q) begin
            out_code_q <= code_upd;
            out_data_q <= data_q;
            out_err_q  <= 1'b0;
          end else begin
            out_code_q <= code_q;
            out_err_q  <= dec_err;
            out_data_q <= dec_err ? '0 : step_val[DATA_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fns_codec_seq.sv
// Scoreboarded bench for fns_codec_seq: encode, decode, bypass,
// backpressure with same-edge retire/accept, and mid-run reset.
module tb_fns_codec_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 12;

  typedef struct packed {
    logic          mode;
    logic          err;
    logic [DW-1:0] data;
    logic [CW-1:0] code;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic          in_err = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_code = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_mode;
  logic          out_err;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_code;

  res_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  fns_codec_seq #(.DATA_W(DW), .CODE_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_err    (in_err),
    .in_data   (in_data),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_err   (out_err),
    .out_data  (out_data),
    .out_code  (out_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic int unsigned fw(input int unsigned i);
    int unsigned w [CW];
    w[0] = 1;
    w[1] = 2;
    for (int k = 2; k < CW; k++) w[k] = w[k-1] + w[k-2];
    return w[i];
  endfunction

  function automatic res_t model(input logic mode, input logic err,
                                 input logic [DW-1:0] data, input logic [CW-1:0] code);
    res_t        r;
    int unsigned rem, sum;
    logic        adj;
    r.mode = mode;
    if (err) begin
      r.err  = 1'b1;
      r.data = mode ? code[DW-1:0] : data;
      r.code = mode ? code : CW'(data);
    end else if (!mode) begin
      rem    = data;
      r.code = '0;
      for (int i = CW - 1; i >= 0; i--) begin
        if (rem >= fw(i)) begin
          r.code[i] = 1'b1;
          rem = rem - fw(i);
        end
      end
      r.data = data;
      r.err  = 1'b0;
    end else begin
      sum = 0;
      adj = 1'b0;
      for (int i = 0; i < CW; i++) begin
        if (code[i]) sum = sum + fw(i);
        if (i < CW - 1 && code[i] && code[i+1]) adj = 1'b1;
      end
      r.code = code;
      r.err  = adj || (sum > 255);
      r.data = r.err ? '0 : DW'(sum);
    end
    return r;
  endfunction

  function automatic res_t observed();
    return {out_mode, out_err, out_data, out_code};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic mode, input logic err,
                      input logic [DW-1:0] data, input logic [CW-1:0] code);
    in_mode  = mode;
    in_err   = err;
    in_data  = data;
    in_code  = code;
    in_valid = 1'b1;
    exp_q.push_back(model(mode, err, data, code));
    tick();
    in_valid = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    total++;
    if (observed() !== res_t'(0)) begin bad++; $display("FAIL reset_outs: got %h want 0", observed()); end
  endtask

  task automatic test_encode();
    int   n;
    res_t e;
    logic [DW-1:0] vals [8];
    vals = '{8'd100, 8'd255, 8'd1, 8'd254, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int k = 4; k < 8; k++) vals[k] = DW'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) begin
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL enc_ready: got %b want 1", in_ready); end
      send(1'b0, 1'b0, vals[k], '0);
      wait_valid(n);
      total++;
      if (n !== CW) begin bad++; $display("FAIL enc_latency: got %0d want %0d", n, CW); end
      e = exp_q.pop_front();
      total++;
      if (observed() !== e) begin bad++; $display("FAIL enc_result: got %h want %h", observed(), e); end
      if (k == 0) begin
        total++;
        if (out_code !== 12'h214) begin bad++; $display("FAIL enc_100: got %h want 214", out_code); end
      end
      if (k == 1) begin
        total++;
        if (out_code !== 12'h841) begin bad++; $display("FAIL enc_255: got %h want 841", out_code); end
      end
      retire();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL enc_retire: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
      end
    end
  endtask

  task automatic test_decode();
    int   n;
    res_t e;
    logic [CW-1:0] codes [10];
    codes = '{12'h841, 12'h003, 12'hA00, 12'h000, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
    for (int k = 4; k < 10; k++) begin
      if (k % 2 == 0) codes[k] = model(1'b0, 1'b0, DW'($urandom_range(0, 255)), '0).code;
      else            codes[k] = CW'($urandom_range(0, 4095));
    end
    for (int k = 0; k < 10; k++) begin
      send(1'b1, 1'b0, '0, codes[k]);
      wait_valid(n);
      total++;
      if (n !== CW) begin bad++; $display("FAIL dec_latency: got %0d want %0d", n, CW); end
      e = exp_q.pop_front();
      total++;
      if (observed() !== e) begin bad++; $display("FAIL dec_result: got %h want %h", observed(), e); end
      if (k == 0) begin
        total++;
        if ({out_mode, out_err, out_data} !== {1'b1, 1'b0, 8'd255}) begin
          bad++; $display("FAIL dec_841: got m=%b e=%b d=%0d want m=1 e=0 d=255", out_mode, out_err, out_data);
        end
      end
      if (k == 1 || k == 2) begin
        total++;
        if ({out_err, out_data} !== {1'b1, 8'd0}) begin
          bad++; $display("FAIL dec_err_%h: got e=%b d=%0d want e=1 d=0", codes[k], out_err, out_data);
        end
      end
      retire();
    end
  endtask

  task automatic test_bypass();
    int   n;
    res_t e;
    send(1'b0, 1'b1, 8'h5A, '0);
    wait_valid(n);
    total++;
    if (n !== 0) begin bad++; $display("FAIL byp_latency: got %0d edges want 0 after accept", n); end
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin bad++; $display("FAIL byp_enc: got %h want %h", observed(), e); end
    total++;
    if ({out_err, out_data, out_code} !== {1'b1, 8'h5A, 12'h05A}) begin
      bad++; $display("FAIL byp_5a: got e=%b d=%h c=%h want e=1 d=5a c=05a", out_err, out_data, out_code);
    end
    retire();
    send(1'b1, 1'b1, '0, 12'hABC);
    wait_valid(n);
    e = exp_q.pop_front();
    total++;
    if (n !== 0 || observed() !== e) begin
      bad++; $display("FAIL byp_dec: got n=%0d %h want n=0 %h", n, observed(), e);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    int   n;
    res_t e, snap;
    send(1'b0, 1'b0, 8'd77, '0);
    wait_valid(n);
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin bad++; $display("FAIL bp_result: got %h want %h", observed(), e); end
    snap = observed();
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (observed() !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: got %h v=%b r=%b want %h v=1 r=0", observed(), out_valid, in_ready, snap);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready: got %b want 1", in_ready); end
    send(1'b0, 1'b0, 8'd200, '0);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_retire: got %b want 0", out_valid); end
    wait_valid(n);
    total++;
    if (n !== CW) begin bad++; $display("FAIL bp_latency: got %0d want %0d", n, CW); end
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin bad++; $display("FAIL bp_second: got %h want %h", observed(), e); end
    retire();
  endtask

  task automatic test_reset_midrun();
    int   n;
    res_t e;
    send(1'b0, 1'b0, 8'd200, '0);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete(exp_q.size() - 1);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_run: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    total++;
    if (observed() !== res_t'(0)) begin bad++; $display("FAIL rst_outs: got %h want 0", observed()); end
    send(1'b0, 1'b0, 8'd0, '0);
    wait_valid(n);
    e = exp_q.pop_front();
    total++;
    if (n !== CW || observed() !== e || out_code !== 12'h000) begin
      bad++; $display("FAIL rst_enc0: got n=%0d %h want n=%0d %h", n, observed(), CW, e);
    end
    retire();
  endtask

  initial begin
    test_reset();
    test_encode();
    test_decode();
    test_bypass();
    test_back_to_back();
    test_reset_midrun();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fns_codec_seq.md
Name: fns_codec_seq

Overview:
- Parametrised, multi-cycle Fibonacci-numeral-system (FNS) codec for the CAC link.
- Encodes binary words into Zeckendorf FNS codewords (no two adjacent ones), or decodes codewords back to binary, one weight per clock.
- Supersedes the fixed single-stage Fibonacci adder cells: arbitrary width, selectable mode, valid/ready handshake and sticky error reporting.
- Sits between the bus-side datapath and the CAC line driver/receiver.

Parameters:
- DATA_W, 8, binary data width.
- CODE_W, 12, FNS codeword width. Weights are w0=1, w1=2, w(i)=w(i-1)+w(i-2). Elaboration fails unless w(CODE_W) >= 2^DATA_W.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous, active-low reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, request accepted when in_valid and in_ready are both high at an edge.
- in_mode, input, 1, 0 = encode, 1 = decode.
- in_err, input, 1, upstream error; forces bypass.
- in_data, input, DATA_W, binary operand (encode).
- in_code, input, CODE_W, codeword operand (decode).
- out_valid, output, 1, result valid; held until out_ready.
- out_ready, input, 1, downstream accept.
- out_mode, output, 1, mode of the result.
- out_err, output, 1, result error flag.
- out_data, output, DATA_W, binary result, or echo of the operand.
- out_code, output, CODE_W, codeword result, or echo of the operand.

Behaviour:
- Reset:
  - rst_n low at an edge sends the FSM to IDLE, from any state including mid-RUN; the in-flight operation is discarded.
  - All outputs go to 0 except in_ready, which is 1 after reset.
- FSM states are IDLE, RUN and DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Registered state only; no combinational path from in_valid.
- Accept with in_err=0: operands are latched, idx=CODE_W-1, and the FSM enters RUN.
- Accept with in_err=1 (bypass): the FSM goes straight to DONE with out_err=1.
  - Encode: out_code = zero-extended in_data, out_data = in_data.
  - Decode: out_data = in_code[DATA_W-1:0], out_code = in_code.
  - Latency is 1 cycle.
- RUN, encode: each edge processes weight idx.
  - If residual >= w(idx): code[idx]=1 and residual -= w(idx).
  - idx then decrements.
- RUN, decode: each edge processes bit idx.
  - If code[idx]=1, acc += w(idx). acc is DATA_W+1 bits wide and saturating.
  - If code[idx] & code[idx+1] (idx < CODE_W-1), err is set sticky.
- The edge that processes idx=0 moves the FSM to DONE with out_valid=1. Latency is exactly CODE_W cycles from the accept edge to out_valid high.
- Encode result:
  - out_code = codeword, out_data = original in_data, out_err=0.
  - The greedy MSB-first algorithm guarantees no adjacent ones.
- Decode result:
  - If there are adjacent ones or acc > 2^DATA_W-1: out_err=1 and out_data=0.
  - Otherwise out_data = acc.
  - out_code = original in_code in both cases.
- DONE:
  - All outputs are stable while out_ready=0.
  - out_ready=1 without a new accept: the FSM goes to IDLE and out_valid drops at that edge.
  - out_ready=1 together with in_valid=1 at the same edge: the result is retired and the new request is accepted in that edge (RUN, or DONE for bypass).
- Result registers update only at DONE entry; they do not change during RUN.
- Weight arithmetic is unsigned. Residual and weight compare use max(DATA_W, bits(w(CODE_W-1))).

Decomposition:
- Package fns_pkg holds:
  - fns_weight(i), a constant function.
  - The DATA_W/CODE_W range check.
  - The state enum {IDLE, RUN, DONE}.
- Sub-module fns_step: combinational single-weight step.
  - Inputs: mode, residual/acc, weight, code bit pair.
  - Outputs: next residual/acc, code bit, adjacency error.
  - Instanced once and time-multiplexed by idx.

Test Plan:
- Encode 8'd100, in_err=0 -> out_valid exactly 12 cycles after accept; out_code=12'h214 (89+8+3), out_err=0, out_data=8'd100.
- Encode 8'd255 -> out_code=12'h841 (233+21+1). Then decode 12'h841 -> out_data=8'd255, out_err=0, out_mode=1.
- Decode 12'h003 -> out_err=1, out_data=0 (adjacent ones). Decode 12'hA00 (233+89=322) -> out_err=1, out_data=0 (overflow).
- Bypass: in_err=1, encode, in_data=8'h5A -> out_valid 1 cycle after accept; out_code=12'h05A, out_data=8'h5A, out_err=1.
- Backpressure: out_ready=0 for 5 cycles -> outputs stable and in_ready=0. Then out_ready=1 with in_valid=1 -> retire and accept at the same edge, and the next out_valid appears 12 cycles later.
- Reset: rst_n=0 for one edge at idx=5 during RUN -> IDLE, out_valid=0, in_ready=1. The next encode of 8'd0 returns out_code=12'h000.
